// File: rtl/disp_pkg.sv
// Shared display-path definitions: stepper FSM state width, encodings and
// the next-state rule shared by every state-machine user.
package disp_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] S_AUTO   = 2'd1;
    localparam logic [STATE_W-1:0] S_MANUAL = 2'd2;

    // Valid states follow run_en/mode directly; the unused code falls back to idle.
    function automatic logic [STATE_W-1:0] next_state(
        input logic [STATE_W-1:0] cur,
        input logic               run_en,
        input logic               mode
    );
        logic [STATE_W-1:0] nxt;
        nxt = S_IDLE;
        case (cur)
            S_IDLE, S_AUTO, S_MANUAL: nxt = !run_en ? S_IDLE : (mode ? S_MANUAL : S_AUTO);
            default:                  nxt = S_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with history register; outputs the synchronised level
// and a registered one-cycle pulse on each rising edge of it.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic hist;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            hist  <= RST_VAL;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= sync2;
            rise  <= sync2 & ~hist;
        end
    end

    assign level = sync2;

endmodule

// File: rtl/mem_addr_stepper.sv
// Memory-viewer address walker: advances on slow_clk ticks (auto) or button
// presses (manual). Define STEP_DEBOUNCE_EN to debounce step_btn over DEB_CYCLES clocks.
module mem_addr_stepper
    import disp_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int LAST_ADDR  = 31,
    parameter int DEB_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slow_clk,
    input  logic               run_en,
    input  logic               mode,
    input  logic               step_btn,
    input  logic               clr_addr,
    output logic [ADDR_W-1:0]  addr,
    output logic               addr_stb,
    output logic               wrap,
    output logic [STATE_W-1:0] state
);

    logic tick;
    logic step;
    logic slow_level_unused;

    // Resetting high means a slow_clk already high at release is not seen as a rise.
    sync_edge_det #(.RST_VAL(1'b1)) u_slow_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (slow_clk),
        .level (slow_level_unused),
        .rise  (tick)
    );

`ifdef STEP_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             btn_level;
    logic             btn_rise_unused;
    logic [CNT_W-1:0] deb_cnt;
    logic             btn_deb;
    logic             btn_deb_q;

    sync_edge_det #(.RST_VAL(1'b0)) u_btn_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (step_btn),
        .level (btn_level),
        .rise  (btn_rise_unused)
    );

    // A level change is accepted only after it has held for DEB_CYCLES clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
        end else begin
            btn_deb_q <= btn_deb;
            if (btn_level == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                btn_deb <= btn_level;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign step = btn_deb & ~btn_deb_q;
`else
    localparam int DEB_CYCLES_UNUSED = DEB_CYCLES;

    logic btn_level_unused;

    sync_edge_det #(.RST_VAL(1'b0)) u_btn_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (step_btn),
        .level (btn_level_unused),
        .rise  (step)
    );
`endif

    logic              advance;
    logic              at_last;
    logic [ADDR_W-1:0] addr_inc;

    // Decided from the state held before this edge's transition.
    assign advance  = ((state == S_AUTO) && tick) || ((state == S_MANUAL) && step);
    assign at_last  = (addr == ADDR_W'(LAST_ADDR));
    assign addr_inc = at_last ? '0 : addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            addr_stb <= 1'b0;
            wrap     <= 1'b0;
            state    <= S_IDLE;
        end else begin
            state    <= next_state(state, run_en, mode);
            addr_stb <= 1'b0;
            wrap     <= 1'b0;
            if (clr_addr) begin
                addr     <= '0;
                addr_stb <= (addr != '0);
            end else if (advance) begin
                addr     <= addr_inc;
                addr_stb <= 1'b1;
                wrap     <= at_last;
            end
        end
    end

endmodule

// File: tb/tb_mem_addr_stepper.sv
// Self-checking bench for mem_addr_stepper: randomised slow_clk/button stimulus
// against an address-walk model kept as plain modular arithmetic.
module tb_mem_addr_stepper;

    localparam int ADDR_W = 5;
    localparam int LAST   = 31;
    localparam int DEB    = 4;

    logic              clk;
    logic              rst;
    logic              slow_clk;
    logic              run_en;
    logic              mode;
    logic              step_btn;
    logic              clr_addr;
    logic [ADDR_W-1:0] addr;
    logic              addr_stb;
    logic              wrap;
    logic [1:0]        state;

    int n_tests;
    int n_fail;
    int stb_total;
    int exp_addr;

    mem_addr_stepper #(
        .ADDR_W     (ADDR_W),
        .LAST_ADDR  (LAST),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .slow_clk (slow_clk),
        .run_en   (run_en),
        .mode     (mode),
        .step_btn (step_btn),
        .clr_addr (clr_addr),
        .addr     (addr),
        .addr_stb (addr_stb),
        .wrap     (wrap),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges, sampling 1 ns after each; tallies strobes seen.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (addr_stb) stb_total++;
        end
    endtask

    // One slow_clk period; expect_adv says whether the walk should move.
    task automatic send_tick(input bit expect_adv);
        int exp_next;
        int lat;
        bit seen;
        exp_next = (exp_addr + 1) % (LAST + 1);
        slow_clk = 1'b1;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            cyc(1);
            if (addr_stb) begin
                seen = 1'b1;
                lat  = k - 1;
            end
        end
        if (expect_adv) begin
            check("tick_seen", seen, 1);
            check("tick_latency", lat, 3);
            check("tick_addr", addr, exp_next);
            check("tick_wrap", wrap, (exp_next == 0));
            exp_addr = exp_next;
            cyc(1);
            check("stb_one_cycle", addr_stb, 0);
            check("wrap_one_cycle", wrap, 0);
        end else begin
            check("no_adv_stb", seen, 0);
            check("no_adv_addr", addr, exp_addr);
        end
        cyc($urandom_range(0, 3));
        slow_clk = 1'b0;
        cyc($urandom_range(3, 6));
    endtask

    // Button pulse of len cycles followed by gap idle cycles; returns strobes seen.
    task automatic press(input int len, input int gap, output int stbs);
        int start;
        start = stb_total;
        step_btn = 1'b1;
        cyc(len);
        step_btn = 1'b0;
        cyc(gap);
        stbs = stb_total - start;
    endtask

    initial begin
        int stbs;
        int exp_steps;
        int got_steps;
        int len;
        int start;

        n_tests   = 0;
        n_fail    = 0;
        stb_total = 0;
        exp_addr  = 0;
        rst       = 1'b1;
        slow_clk  = 1'b1;
        run_en    = 1'b0;
        mode      = 1'b0;
        step_btn  = 1'b0;
        clr_addr  = 1'b0;

        // Reset with slow_clk high; no tick may appear after release.
        cyc(4);
        check("rst_addr", addr, 0);
        check("rst_state", state, 0);
        check("rst_stb", addr_stb, 0);
        check("rst_wrap", wrap, 0);
        rst = 1'b0;
        start = stb_total;
        cyc(20);
        check("post_rst_no_stb", stb_total - start, 0);
        check("post_rst_addr", addr, 0);

        // Auto walk: first three ticks, then random-gap ticks up to the wrap.
        slow_clk = 1'b0;
        run_en = 1'b1;
        mode   = 1'b0;
        cyc(1);
        check("enter_auto", state, 1);
        cyc(3);
        for (int i = 0; i < 3; i++) send_tick(1'b1);
        check("auto_addr3", addr, 3);
        while (exp_addr != 30) send_tick(1'b1);
        send_tick(1'b1);
        check("auto_addr31", addr, 31);
        send_tick(1'b1);
        check("auto_wrapped", addr, 0);
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) send_tick(1'b1);

        // Manual: glitch then a real press, then random presses/glitches.
        mode = 1'b1;
        cyc(1);
        check("enter_manual", state, 2);
        exp_steps = 0;
        got_steps = 0;
        press(2, 15, stbs);
        got_steps += stbs;
`ifndef STEP_DEBOUNCE_EN
        exp_steps += 1;
`endif
        press(10, 20, stbs);
        got_steps += stbs;
        exp_steps += 1;
        check("manual_glitch_press", got_steps, exp_steps);
        exp_addr = (exp_addr + exp_steps) % (LAST + 1);
        check("manual_addr", addr, exp_addr);
        exp_steps = 0;
        got_steps = 0;
        for (int i = 0; i < 6; i++) begin
            len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(6, 12));
            press(len, 16, stbs);
            got_steps += stbs;
`ifdef STEP_DEBOUNCE_EN
            if (len >= DEB) exp_steps += 1;
`else
            exp_steps += 1;
`endif
        end
        check("manual_random_steps", got_steps, exp_steps);
        exp_addr = (exp_addr + exp_steps) % (LAST + 1);
        check("manual_random_addr", addr, exp_addr);
        send_tick(1'b0);
        send_tick(1'b0);

        // clr_addr coinciding with an advance at addr=17.
        mode = 1'b0;
        cyc(1);
        check("back_to_auto", state, 1);
        while (exp_addr != 17) send_tick(1'b1);
        slow_clk = 1'b1;
        cyc(3);
        check("clr_pre_addr", addr, 17);
        clr_addr = 1'b1;
        cyc(1);
        clr_addr = 1'b0;
        exp_addr = 0;
        check("clr_addr", addr, 0);
        check("clr_stb", addr_stb, 1);
        check("clr_wrap", wrap, 0);
        start = stb_total;
        slow_clk = 1'b0;
        cyc(6);
        check("clr_discard_adv", stb_total - start, 0);
        check("clr_hold_addr", addr, 0);
        clr_addr = 1'b1;
        cyc(1);
        clr_addr = 1'b0;
        check("clr_at_zero_stb", addr_stb, 0);
        check("clr_at_zero_addr", addr, 0);

        // run_en drop mid-walk, then reset on an advance edge.
        while (exp_addr != 9) send_tick(1'b1);
        run_en = 1'b0;
        cyc(1);
        check("idle_state", state, 0);
        send_tick(1'b0);
        send_tick(1'b0);
        check("idle_hold_addr", addr, 9);
        run_en = 1'b1;
        cyc(1);
        check("reenter_auto", state, 1);
        while (exp_addr != 12) send_tick(1'b1);
        slow_clk = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("midrst_addr", addr, 0);
        check("midrst_stb", addr_stb, 0);
        check("midrst_wrap", wrap, 0);
        check("midrst_state", state, 0);
        rst = 1'b0;
        start = stb_total;
        cyc(8);
        slow_clk = 1'b0;
        cyc(6);
        check("post_midrst_no_stb", stb_total - start, 0);
        check("post_midrst_addr", addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
